// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Brief    : Programmable serial pattern detector with match counting and
//            run sequencing (IDLE / ARMED / DONE).
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             X,
  input  logic             X_valid,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [PAT_W-1:0]  PAT_RST   = (PAT_W == 4) ? PAT_W'(4'b0110) : '0;

  logic [1:0]       state;
  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic [CNT_W-1:0] target;
  logic [PAT_W-1:0] hist;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic [CNT_W-1:0]  count_inc;
  logic              hit;

  // Candidate window after taking the current bit; a hit needs a full window.
  always_comb begin
    hist_shift = {hist[PAT_W-2:0], X};
    fill_inc   = (fill == FILL_FULL) ? fill : fill + 1'b1;
    count_inc  = (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
    hit        = (fill_inc == FILL_FULL) && (hist_shift == pattern);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      pattern <= PAT_RST;
      overlap <= 1'b1;
      target  <= '0;
      hist    <= '0;
      fill    <= '0;
      count   <= '0;
      match   <= 1'b0;
    end else begin
      match <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        hist  <= '0;
        fill  <= '0;
      end else begin
        case (state)
          ST_ARMED: begin
            if (X_valid) begin
              hist <= hist_shift;
              fill <= fill_inc;
              if (hit) begin
                match <= 1'b1;
                count <= count_inc;
                // Non-overlapping mode requires a completely fresh window.
                if (!overlap) fill <= '0;
                if ((target != '0) && (count_inc == target)) state <= ST_DONE;
              end
            end
          end
          default: begin
            if (cfg_we) begin
              pattern <= cfg_pattern;
              overlap <= cfg_overlap;
              target  <= cfg_target;
            end
            if (start) begin
              state <= ST_ARMED;
              count <= '0;
              hist  <= '0;
              fill  <= '0;
            end
          end
        endcase
      end
    end
  end

  assign busy = (state == ST_ARMED);
  assign done = (state == ST_DONE);

endmodule
`default_nettype wire
